// File: rtl/mu0_mem_resp.sv
// MU0 bus memory responder: captures a Rd/Wr request, waits WAIT_CYCLES,
// then commits or fetches one word and pulses Ready (and Err on Rd+Wr).
module mu0_mem_resp #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_BITS  = 12
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [11:0] Addr,
    input  logic [15:0] Din,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] Dout,
    output logic        Ready,
    output logic        Err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [DEPTH_BITS-1:0] cap_addr;
    logic [15:0]           cap_din;
    logic                  cap_rd, cap_wr;

    logic [15:0] mem [2**DEPTH_BITS];

    logic [DEPTH_BITS-1:0] eff_addr;
    logic [15:0]           eff_din;
    logic                  eff_rd, eff_wr, go_ack;

    // Upper address bits are deliberately ignored so addresses alias.
    logic addr_unused;
    assign addr_unused = ^Addr;

    // With zero wait states the completion happens on the capture edge itself,
    // so the live bus values stand in for the captured ones.
    always_comb begin
        eff_addr = cap_addr;
        eff_din  = cap_din;
        eff_rd   = cap_rd;
        eff_wr   = cap_wr;
        go_ack   = 1'b0;
        if (state == S_IDLE) begin
            eff_addr = Addr[DEPTH_BITS-1:0];
            eff_din  = Din;
            eff_rd   = Rd;
            eff_wr   = Wr;
            go_ack   = (WAIT_CYCLES == 0) && (Rd || Wr);
        end else if (state == S_WAIT) begin
            go_ack   = (cnt == 4'd1);
        end
    end

    // Memory is never cleared; a reset on the commit edge drops the write.
    always_ff @(posedge Clk) begin
        if (!Reset && go_ack && eff_wr && !eff_rd)
            mem[eff_addr] <= eff_din;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            cap_addr <= '0;
            cap_din  <= 16'h0000;
            cap_rd   <= 1'b0;
            cap_wr   <= 1'b0;
            Dout     <= 16'h0000;
            Ready    <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Ready <= 1'b0;
            Err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Rd || Wr) begin
                        cap_addr <= Addr[DEPTH_BITS-1:0];
                        cap_din  <= Din;
                        cap_rd   <= Rd;
                        cap_wr   <= Wr;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACK;
                        end else begin
                            cnt   <= WAIT_LD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_ACK;
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (go_ack) begin
                Ready <= 1'b1;
                if (eff_rd && eff_wr)
                    Err <= 1'b1;
                else if (eff_rd)
                    Dout <= mem[eff_addr];
            end
        end
    end

endmodule

// File: tb/tb_mu0_mem_resp.sv
// Directed scoreboard bench for mu0_mem_resp: four instances cover wait-state
// counts 0/1/3 and an 8-bit-deep aliasing configuration.
module tb_mu0_mem_resp;

    logic        Clk;
    logic        rst   [4];
    logic [11:0] addr  [4];
    logic [15:0] din   [4];
    logic        rd    [4];
    logic        wr    [4];
    logic [15:0] dout  [4];
    logic        ready [4];
    logic        err   [4];

    int wc    [4] = '{0, 1, 3, 1};
    int dbits [4] = '{12, 12, 12, 8};

    mu0_mem_resp #(.WAIT_CYCLES(0), .DEPTH_BITS(12)) u_w0 (
        .Clk(Clk), .Reset(rst[0]), .Addr(addr[0]), .Din(din[0]), .Rd(rd[0]), .Wr(wr[0]),
        .Dout(dout[0]), .Ready(ready[0]), .Err(err[0]));
    mu0_mem_resp #(.WAIT_CYCLES(1), .DEPTH_BITS(12)) u_w1 (
        .Clk(Clk), .Reset(rst[1]), .Addr(addr[1]), .Din(din[1]), .Rd(rd[1]), .Wr(wr[1]),
        .Dout(dout[1]), .Ready(ready[1]), .Err(err[1]));
    mu0_mem_resp #(.WAIT_CYCLES(3), .DEPTH_BITS(12)) u_w3 (
        .Clk(Clk), .Reset(rst[2]), .Addr(addr[2]), .Din(din[2]), .Rd(rd[2]), .Wr(wr[2]),
        .Dout(dout[2]), .Ready(ready[2]), .Err(err[2]));
    mu0_mem_resp #(.WAIT_CYCLES(1), .DEPTH_BITS(8)) u_a8 (
        .Clk(Clk), .Reset(rst[3]), .Addr(addr[3]), .Din(din[3]), .Rd(rd[3]), .Wr(wr[3]),
        .Dout(dout[3]), .Ready(ready[3]), .Err(err[3]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] dout;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] mdl  [4][4096];
    logic [15:0] last [4];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives the request, holds it until Ready, and
    // returns at the negedge of the following idle cycle.
    task automatic xact(input int d, input bit r, input bit w,
                        input logic [11:0] a, input logic [15:0] dd, input string tag);
        exp_t e, got;
        int   lat;
        int   ai;
        ai    = int'(a) & ((1 << dbits[d]) - 1);
        e.lat = wc[d] + 1;
        e.err = r && w;
        e.dout = last[d];
        if (!(r && w)) begin
            if (w) mdl[d][ai] = dd;
            else if (r) e.dout = mdl[d][ai];
        end
        last[d] = e.dout;
        sb.push_back(e);
        rd[d] = r; wr[d] = w; addr[d] = a; din[d] = dd;
        lat = 0;
        do begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end while (!ready[d] && lat < 40);
        rd[d] = 1'b0; wr[d] = 1'b0;
        got = sb.pop_front();
        chk({tag, " ready"}, 32'(ready[d]), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(got.lat));
        chk({tag, " dout"}, 32'(dout[d]), 32'(got.dout));
        chk({tag, " err"}, 32'(err[d]), 32'(got.err));
        @(negedge Clk);
        chk({tag, " ready_drop"}, 32'(ready[d]), 32'd0);
        chk({tag, " err_drop"}, 32'(err[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 12'h000; din[d] = 16'h0000; last[d] = 16'h0000;
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset ready%0d", d), 32'(ready[d]), 32'd0);
            chk($sformatf("reset err%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("reset dout%0d", d), 32'(dout[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge Clk);

        // Write then read with one wait state
        xact(1, 0, 1, 12'h005, 16'hAAAA, "w1 wr 005");
        xact(1, 1, 0, 12'h005, 16'h0000, "w1 rd 005");

        // Rd+Wr together: error pulse, no write, Dout untouched
        xact(1, 0, 1, 12'h010, 16'h7777, "w1 wr 010");
        xact(1, 1, 1, 12'h010, 16'h1234, "w1 rdwr 010");
        xact(1, 1, 0, 12'h010, 16'h0000, "w1 rd 010");

        // Back-to-back write then read
        xact(1, 0, 1, 12'h001, 16'h1111, "w1 wr 001");
        xact(1, 1, 0, 12'h001, 16'h0000, "w1 rd 001");

        // Latency sweep over 0/1/3 wait states
        for (int d = 0; d < 3; d++) begin
            xact(d, 0, 1, 12'h0AB, 16'hBBBB, $sformatf("sweep%0d wr", d));
            xact(d, 1, 0, 12'h0AB, 16'h0000, $sformatf("sweep%0d rd", d));
        end

        // Reset in WAIT drops the pending write
        xact(2, 0, 1, 12'h020, 16'h5555, "w3 wr 020 old");
        rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 12'h020; din[2] = 16'hCCCC;
        @(posedge Clk);
        @(negedge Clk);
        chk("w3 in wait ready", 32'(ready[2]), 32'd0);
        rst[2] = 1'b1; wr[2] = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        rst[2] = 1'b0;
        chk("midrst ready", 32'(ready[2]), 32'd0);
        chk("midrst err", 32'(err[2]), 32'd0);
        chk("midrst dout", 32'(dout[2]), 32'd0);
        last[2] = 16'h0000;
        repeat (4) begin
            @(negedge Clk);
            chk("midrst no late ready", 32'(ready[2]), 32'd0);
        end
        xact(2, 1, 0, 12'h020, 16'h0000, "w3 rd 020 after rst");

        // Address aliasing with 8 decoded bits
        xact(3, 0, 1, 12'h1FF, 16'hDEAD, "a8 wr 1FF");
        xact(3, 1, 0, 12'h0FF, 16'h0000, "a8 rd 0FF");
        xact(3, 0, 1, 12'h234, 16'hBEEF, "a8 wr 234");
        xact(3, 1, 0, 12'hF34, 16'h0000, "a8 rd F34");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mu0_mem_resp.md
# mu0_mem_resp

Memory responder for the MU0 16-bit processor bus. It sits on the far side of the MU0 address/data interface, the end the CPU's address multiplexer drives, and services word reads and writes. The block accepts a Rd or Wr request, inserts a parameterised number of wait states, commits or fetches the word, and signals completion with a one-cycle Ready pulse. The memory array is internal and is not cleared by reset.

## Interface
- WAIT_CYCLES, default 1: wait states between request capture and completion; legal range 0–15.
- DEPTH_BITS, default 12: number of address bits decoded; array depth is 2^DEPTH_BITS words; legal range 4–12.
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Addr  input  12  word address from the CPU.
- Din  input  16  write data from the CPU.
- Rd  input  1  read request; held by the CPU until Ready.
- Wr  input  1  write request; held by the CPU until Ready.
- Dout  output  16  read data; registered.
- Ready  output  1  one-cycle completion pulse; registered.
- Err  output  1  one-cycle protocol-error pulse, coincident with Ready; registered.

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, WAIT, ACK.
- IDLE: if Rd or Wr is sampled high, capture Addr[DEPTH_BITS-1:0], Din and the operation. If WAIT_CYCLES=0, go to ACK; otherwise load the counter with WAIT_CYCLES and go to WAIT. If neither is high, stay in IDLE.
- WAIT: decrement the counter on each edge. Go to ACK on the edge where the counter is 1. Addr, Din, Rd and Wr are ignored in WAIT; only the captured values are used.
- Transition into ACK:
  - Captured write: memory[addr] <= captured Din.
  - Captured read: Dout <= memory[addr].
  - Ready <= 1 for exactly one cycle.
- ACK: always go to IDLE on the next edge; Ready and Err return to 0.
- Rd and Wr both high at capture: treated as an error. No write occurs, Dout is unchanged, and Err and Ready pulse together.
- Addr bits above DEPTH_BITS are ignored, so addresses alias and wrap. With DEPTH_BITS=8, address 0x1FF maps to word 0xFF.
- Dout holds its value until the next successful read completes. Writes and errors never change Dout.
- Reset, including mid-WAIT or in ACK:
  - state becomes IDLE; Ready, Err and the counter go to 0; Dout goes to 16'h0000.
  - Any captured but uncommitted write is dropped.
  - Memory contents are preserved.
- Memory contents after power-up are undefined (X in simulation) until written.

## Timing
- Request sampled at edge E0 while in IDLE. Ready is high during the cycle after edge E0+WAIT_CYCLES, so read/write latency is WAIT_CYCLES+1 cycles.
- Dout is valid in the same cycle Ready is high.
- A write is visible to any read captured at or after the edge on which Ready falls.
- The CPU samples Ready at the end of its high cycle and may drop the request, or present a new one, in the next cycle.
  - The block is in IDLE in that cycle and captures a new request at its end.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- A request held high past Ready is recaptured as a new transaction. The CPU must deassert Rd and Wr in the cycle after Ready unless it intends a repeat.
- Reset dominates every other condition on the same edge.

## Test plan
- Write then read, WAIT_CYCLES=1: Wr with Addr=0x005, Din=0xAAAA, then Rd with Addr=0x005. Ready must pulse exactly 2 cycles after each capture, Dout=0xAAAA with the second Ready, and Err stays 0.
- Latency sweep over WAIT_CYCLES = 0, 1, 3: Rd to a preloaded word 0xBBBB. Ready must arrive after 1, 2 and 4 cycles respectively, with Dout=0xBBBB.
- Rd and Wr both high with Addr=0x010, Din=0x1234: Ready and Err must pulse together. A following read of 0x010 must return the prior contents, and Dout must be unchanged at the error pulse.
- Reset mid-operation: Wr with Addr=0x020, Din=0xCCCC, then Reset asserted in WAIT with WAIT_CYCLES=3.
  - Ready, Err and Dout must be 0 on the next cycle.
  - A later read of 0x020 must return the old value, not 0xCCCC.
- Back-to-back: Wr 0x001=0x1111, then Rd 0x001 issued in the cycle immediately after Ready. Dout=0x1111 and no missed or duplicate Ready.
- Alias, DEPTH_BITS=8: Wr with Addr=0x1FF, Din=0xDEAD, then Rd with Addr=0x0FF must return 0xDEAD.
